// File: rtl/lap_pkg.sv
// Shared types and constants for the Laplacian frame sequencer.
package lap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } lap_state_e;

  localparam int LAP_ADDR_W       = 17;
  localparam int LAP_INFLIGHT_MAX = 3;
  localparam int LAP_DRAIN_CYCLES = 4;

  typedef struct packed {
    logic [LAP_ADDR_W-1:0] addr;
    logic [7:0]            data;
  } lap_fifo_entry_t;

  localparam int LAP_ENTRY_W = $bits(lap_fifo_entry_t);

  // A result is saturated when it pins to either end of the 8-bit range.
  function automatic logic lap_is_saturated(input logic [7:0] value);
    return (value == 8'h00) || (value == 8'hFF);
  endfunction

endpackage

// File: rtl/lap_result_fifo.sv
// Synchronous result FIFO; pop has priority so a push while full is
// accepted when a pop happens in the same cycle.
module lap_result_fifo
  import lap_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [LAP_ENTRY_W-1:0] wdata,
  output logic [LAP_ENTRY_W-1:0] rdata,
  output logic [CNT_W-1:0]       count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [LAP_ENTRY_W-1:0] mem_q [DEPTH];
  logic [LAP_ENTRY_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   do_push, do_pop;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array needs no reset; empty FIFO contents are never observed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointers and count return to empty on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/lap_frame_ctrl.sv
// Frame sequencer for the 3x3 Laplacian filter: streams a frame from source
// memory into the filter and writes buffered results to destination memory.
// Optional feature macro: LAP_FRAME_STATS_EN (saturated-result counter).
module lap_frame_ctrl
  import lap_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int ADDR_W       = 17,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              src_req,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [7:0]        src_rdata,
  output logic              flt_rst,
  output logic              flt_valid,
  output logic [7:0]        flt_pix,
  input  logic              flt_out_valid,
  input  logic [7:0]        flt_out,
  input  logic [31:0]       flt_row,
  input  logic [31:0]       flt_col,
  output logic              dst_we,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [7:0]        dst_data,
  input  logic              dst_ready,
  output logic [31:0]       sat_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int NPIX  = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(NPIX - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT    = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  REQ_MIN_FREE = CNT_W'(LAP_INFLIGHT_MAX + 1);
  localparam logic [2:0]        DRAIN_LAST   = 3'(LAP_DRAIN_CYCLES - 1);

  lap_state_e        state_q, state_d;
  logic [ADDR_W-1:0] src_addr_q, src_addr_d;
  logic              flt_valid_q, flt_valid_d;
  logic [2:0]        drain_cnt_q, drain_cnt_d;
  logic              ovf_q, ovf_d;

  logic [CNT_W-1:0]       fifo_count;
  logic [CNT_W-1:0]       free_slots;
  logic                   fifo_full, fifo_empty;
  logic                   fifo_pop, fifo_push;
  logic [LAP_ENTRY_W-1:0] head_bits;
  lap_fifo_entry_t        head_entry, push_entry;
  logic [31:0]            pix_index;
  logic [ADDR_W-1:0]      push_addr;

  assign free_slots = DEPTH_CNT - fifo_count;
  assign src_req    = (state_q == ST_STREAM) && (free_slots >= REQ_MIN_FREE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign flt_rst    = rst || (state_q == ST_CLEAR);
  assign flt_valid  = flt_valid_q;
  assign flt_pix    = flt_valid_q ? src_rdata : 8'h00;
  assign src_addr   = src_addr_q;
  assign ovf        = ovf_q;

  assign dst_we     = !fifo_empty;
  assign fifo_pop   = dst_we && dst_ready;
  assign fifo_push  = flt_out_valid && (!fifo_full || fifo_pop);
  assign head_entry = lap_fifo_entry_t'(head_bits);
  assign dst_addr   = fifo_empty ? '0 : ADDR_W'(head_entry.addr);
  assign dst_data   = fifo_empty ? 8'h00 : head_entry.data;

  assign pix_index  = flt_row * 32'(IMAGE_WIDTH) + flt_col;
  assign push_addr  = pix_index[ADDR_W-1:0];

  // Pack the raster address of the result centre with the result byte.
  always_comb begin
    push_entry      = '0;
    push_entry.addr = LAP_ADDR_W'(push_addr);
    push_entry.data = flt_out;
  end

  lap_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (push_entry),
    .rdata (head_bits),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sequencer next-state: address counter, drain timer and overflow flag.
  always_comb begin
    state_d     = state_q;
    src_addr_d  = src_addr_q;
    drain_cnt_d = drain_cnt_q;
    flt_valid_d = src_req;
    ovf_d       = ovf_q || (flt_out_valid && fifo_full && !fifo_pop);
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        src_addr_d = '0;
        state_d    = ST_STREAM;
      end
      ST_STREAM: begin
        if (src_req) begin
          src_addr_d = src_addr_q + ADDR_W'(1);
          if (src_addr_q == LAST_ADDR) begin
            drain_cnt_d = '0;
            state_d     = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q != DRAIN_LAST) begin
          drain_cnt_d = drain_cnt_q + 3'd1;
        end else if (fifo_empty) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      src_addr_q  <= '0;
      drain_cnt_q <= '0;
      flt_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_addr_q  <= src_addr_d;
      drain_cnt_q <= drain_cnt_d;
      flt_valid_q <= flt_valid_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef LAP_FRAME_STATS_EN
  logic [31:0] sat_count_q, sat_count_d;

  // Count accepted results that pinned to 0 or 255; restarts each frame.
  always_comb begin
    sat_count_d = sat_count_q;
    if (state_q == ST_CLEAR) begin
      sat_count_d = '0;
    end else if (fifo_push && lap_is_saturated(flt_out)) begin
      sat_count_d = sat_count_q + 32'd1;
    end
  end

  // Saturation counter register.
  always_ff @(posedge clk) begin
    if (rst) sat_count_q <= '0;
    else     sat_count_q <= sat_count_d;
  end

  assign sat_count = sat_count_q;
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_lap_frame_ctrl.sv
// Directed testbench for lap_frame_ctrl with a 4x3 frame, a source memory
// model and a pass-through stand-in for the filter (result = pixel, with its
// raster row/column). Honours LAP_FRAME_STATS_EN for sat_count expectations.
module tb_lap_frame_ctrl;

  localparam int W     = 4;
  localparam int H     = 3;
  localparam int NPIX  = W * H;
  localparam int AW    = 17;
  localparam int DEPTH = 8;
`ifdef LAP_FRAME_STATS_EN
  localparam int SAT_EXP = 2;
`else
  localparam int SAT_EXP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, ovf, src_req;
  logic [AW-1:0] src_addr;
  logic [7:0]    src_rdata;
  logic          flt_rst, flt_valid;
  logic [7:0]    flt_pix;
  logic          flt_out_valid;
  logic [7:0]    flt_out;
  logic [31:0]   flt_row, flt_col;
  logic          dst_we;
  logic [AW-1:0] dst_addr;
  logic [7:0]    dst_data;
  logic          dst_ready = 1'b1;
  logic [31:0]   sat_count;

  logic          force_en = 1'b0;
  logic          force_valid = 1'b0;
  logic [7:0]    force_data = 8'h00;
  logic [31:0]   force_row = '0;
  logic [31:0]   force_col = '0;

  logic          mdl_valid;
  logic [7:0]    mdl_pix;
  logic [31:0]   mdl_row, mdl_col;
  int            mdl_idx;

  logic [7:0]    src_mem [NPIX];
  int            cyc = 0;
  int            req_addr_q[$];
  int            req_cyc_q[$];
  int            wr_addr_q[$];
  int            wr_data_q[$];
  int            done_cyc_q[$];
  int            checks = 0;
  int            errors = 0;

  lap_frame_ctrl #(
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H),
    .ADDR_W       (AW),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .ovf           (ovf),
    .src_req       (src_req),
    .src_addr      (src_addr),
    .src_rdata     (src_rdata),
    .flt_rst       (flt_rst),
    .flt_valid     (flt_valid),
    .flt_pix       (flt_pix),
    .flt_out_valid (flt_out_valid),
    .flt_out       (flt_out),
    .flt_row       (flt_row),
    .flt_col       (flt_col),
    .dst_we        (dst_we),
    .dst_addr      (dst_addr),
    .dst_data      (dst_data),
    .dst_ready     (dst_ready),
    .sat_count     (sat_count)
  );

  always #5 clk = ~clk;

  assign flt_out_valid = force_en ? force_valid : mdl_valid;
  assign flt_out       = force_en ? force_data  : mdl_pix;
  assign flt_row       = force_en ? force_row   : mdl_row;
  assign flt_col       = force_en ? force_col   : mdl_col;

  // Source memory returns data one cycle after a request.
  always @(posedge clk) begin
    int a;
    a = int'(src_addr);
    if (src_req && a < NPIX) src_rdata <= src_mem[a];
  end

  // Stand-in filter: one-cycle latency, echoes the pixel with its position.
  always @(posedge clk) begin
    if (flt_rst) begin
      mdl_valid <= 1'b0;
      mdl_idx   <= 0;
      mdl_pix   <= 8'h00;
      mdl_row   <= '0;
      mdl_col   <= '0;
    end else begin
      mdl_valid <= flt_valid;
      if (flt_valid) begin
        mdl_pix <= flt_pix;
        mdl_row <= 32'(mdl_idx / W);
        mdl_col <= 32'(mdl_idx % W);
        mdl_idx <= mdl_idx + 1;
      end
    end
  end

  // Log read requests, accepted writes and done pulses.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (src_req) begin
        req_addr_q.push_back(int'(src_addr));
        req_cyc_q.push_back(cyc);
      end
      if (dst_we && dst_ready) begin
        wr_addr_q.push_back(int'(dst_addr));
        wr_data_q.push_back(int'(dst_data));
      end
      if (done) done_cyc_q.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic start_v, input logic ready_v);
    start     = start_v;
    dst_ready = ready_v;
    @(posedge clk);
    #1;
  endtask

  task automatic clearLogs();
    req_addr_q.delete();
    req_cyc_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cyc_q.delete();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"},      busy,      0);
    checkOutput({tag, "_done"},      done,      0);
    checkOutput({tag, "_ovf"},       ovf,       0);
    checkOutput({tag, "_src_req"},   src_req,   0);
    checkOutput({tag, "_flt_valid"}, flt_valid, 0);
    checkOutput({tag, "_dst_we"},    dst_we,    0);
    checkOutput({tag, "_src_addr"},  src_addr,  0);
    checkOutput({tag, "_dst_addr"},  dst_addr,  0);
    checkOutput({tag, "_flt_pix"},   flt_pix,   0);
    checkOutput({tag, "_dst_data"},  dst_data,  0);
    checkOutput({tag, "_sat_count"}, sat_count, 0);
    checkOutput({tag, "_flt_rst"},   flt_rst,   1);
  endtask

  task automatic waitDone(input int budget, input string tag);
    int n = 0;
    while (!done && n < budget) begin
      applyStimulus(1'b0, dst_ready);
      n++;
    end
    checkOutput({tag, "_done_seen"}, done, 1);
  endtask

  task automatic checkFrame(input string tag, input bit contiguous);
    checkOutput({tag, "_req_n"},  req_addr_q.size(), NPIX);
    checkOutput({tag, "_wr_n"},   wr_addr_q.size(),  NPIX);
    checkOutput({tag, "_done_n"}, done_cyc_q.size(), 1);
    for (int i = 0; i < NPIX; i++) begin
      if (i < req_addr_q.size()) checkOutput({tag, "_req_addr"}, req_addr_q[i], i);
      if (i < wr_addr_q.size()) begin
        checkOutput({tag, "_wr_addr"}, wr_addr_q[i], i);
        checkOutput({tag, "_wr_data"}, wr_data_q[i], int'(src_mem[i]));
      end
    end
    if (contiguous && req_cyc_q.size() == NPIX)
      checkOutput({tag, "_req_span"}, req_cyc_q[NPIX-1] - req_cyc_q[0], NPIX - 1);
    checkOutput({tag, "_ovf"},       ovf,       0);
    checkOutput({tag, "_sat_count"}, sat_count, SAT_EXP);
  endtask

  // Bound the whole run in case the DUT never finishes a frame.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence.
  initial begin
    for (int i = 0; i < NPIX; i++) src_mem[i] = 8'(i * 20 + 7);
    src_mem[3] = 8'h00;
    src_mem[5] = 8'hFF;

    // Reset state while rst is held.
    rst = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b1);
    checkResetOutputs("reset");
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1);
    checkOutput("idle_busy", busy, 0);

    // Frame 1: unstalled, with ignored start pulses in STREAM and DONE.
    clearLogs();
    applyStimulus(1'b1, 1'b1);
    checkOutput("f1_clear_busy",    busy,    1);
    checkOutput("f1_clear_flt_rst", flt_rst, 1);
    checkOutput("f1_clear_src_req", src_req, 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("f1_first_req",      src_req,   1);
    checkOutput("f1_first_addr",     src_addr,  0);
    checkOutput("f1_first_fltvalid", flt_valid, 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("f1_fltvalid", flt_valid, 1);
    checkOutput("f1_fltpix",   flt_pix,   32'(src_mem[0]));
    checkOutput("f1_addr1",    src_addr,  1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("f1_stream_start_ign", flt_rst, 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("f1_stream_start_ign2", flt_rst, 0);
    waitDone(100, "f1");
    checkOutput("f1_done_busy", busy, 1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("f1_after_done_busy", busy, 0);
    checkOutput("f1_after_done_done", done, 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("f1_done_start_ign", busy, 0);
    checkFrame("f1", 1'b1);

    // Frame 2: destination stalls for 20 cycles mid-stream.
    clearLogs();
    applyStimulus(1'b1, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b1);
    repeat (20) applyStimulus(1'b0, 1'b0);
    checkOutput("f2_stall_src_req", src_req, 0);
    checkOutput("f2_stall_dst_we",  dst_we,  1);
    checkOutput("f2_stall_busy",    busy,    1);
    checkOutput("f2_stall_ovf",     ovf,     0);
    applyStimulus(1'b0, 1'b1);
    waitDone(200, "f2");
    applyStimulus(1'b0, 1'b1);
    checkFrame("f2", 1'b0);

    // Frame 3: reset at the sixth request, then frame 4 runs clean.
    clearLogs();
    applyStimulus(1'b1, 1'b1);
    for (int n = 0; n < 20; n++) begin
      if (src_req && src_addr == AW'(5)) break;
      applyStimulus(1'b0, 1'b1);
    end
    checkOutput("f3_sixth_req", {31'd0, src_req}, 1);
    checkOutput("f3_sixth_addr", src_addr, 5);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1);
    checkResetOutputs("midrst");
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1);
    checkOutput("midrst_idle", busy, 0);
    clearLogs();
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    waitDone(100, "f4");
    applyStimulus(1'b0, 1'b1);
    checkFrame("f4", 1'b1);

    // Forced result pushes into a full FIFO with the destination stalled.
    clearLogs();
    force_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      force_valid = 1'b1;
      force_data  = 8'(i + 1);
      force_row   = 32'(i / W);
      force_col   = 32'(i % W);
      applyStimulus(1'b0, 1'b0);
      if (i == 7) begin
        checkOutput("ovf_full_no_ovf",  ovf,      0);
        checkOutput("ovf_full_head_a",  dst_addr, 0);
        checkOutput("ovf_full_head_d",  dst_data, 1);
      end
    end
    force_valid = 1'b0;
    checkOutput("ovf_set", ovf, 1);
    repeat (12) applyStimulus(1'b0, 1'b1);
    checkOutput("ovf_sticky", ovf,    1);
    checkOutput("ovf_drained", dst_we, 0);
    checkOutput("ovf_wr_n", wr_data_q.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      if (i < wr_data_q.size()) begin
        checkOutput("ovf_wr_data", wr_data_q[i], i + 1);
        checkOutput("ovf_wr_addr", wr_addr_q[i], i);
      end
    end
    checkOutput("ovf_sat_hold", sat_count, SAT_EXP);
    force_en = 1'b0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1);
    checkOutput("ovf_cleared_by_rst", ovf, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lap_frame_ctrl.md
# lap_frame_ctrl

Frame sequencer for the 3x3 Laplacian filter. On `start`, it reads one grayscale frame from source memory in raster order and streams it into the filter. It buffers the filter's results in a small FIFO and writes them to destination memory under `dst_ready` backpressure, then pulses `done`. It sits between the frame buffers and the filter datapath and is the only block that drives the filter's pixel input.

## Interface
- `IMAGE_WIDTH`, 320, pixels per row.
- `IMAGE_HEIGHT`, 240, rows per frame.
- `ADDR_W`, 17, memory address width; must hold `IMAGE_WIDTH*IMAGE_HEIGHT-1`.
- `FIFO_DEPTH`, 8, result FIFO entries; power of two, ≥8.

- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  begin one frame; honoured only in IDLE.
- `busy`  out  1  high from CLEAR through DONE.
- `done`  out  1  one-cycle pulse at frame end.
- `ovf`  out  1  sticky: result arrived while FIFO full; cleared only by rst.
- `src_req`  out  1  read request.
- `src_addr`  out  ADDR_W  read address.
- `src_rdata`  in  8  read data, valid exactly 1 cycle after `src_req`.
- `flt_rst`  out  1  filter state clear.
- `flt_valid`  out  1  pixel strobe to filter.
- `flt_pix`  out  8  pixel to filter.
- `flt_out_valid`  in  1  filter result strobe.
- `flt_out`  in  8  filter result.
- `flt_row`  in  32  result centre row.
- `flt_col`  in  32  result centre column.
- `dst_we`  out  1  write request; head of FIFO.
- `dst_addr`  out  ADDR_W  write address.
- `dst_data`  out  8  write data.
- `dst_ready`  in  1  destination accepts the write this cycle.
- `sat_count`  out  32  saturated-result count (see Configuration).

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE: `start` moves to CLEAR. `start` in any other state is ignored.
- CLEAR (1 cycle): `flt_rst`=1, pixel counter and `src_addr` are zeroed, then STREAM.
- STREAM:
  - `src_req`=1 when FIFO free slots ≥4, which covers the maximum of 3 results in flight.
  - Each accepted request advances `src_addr` by 1.
  - After the request at address `IMAGE_WIDTH*IMAGE_HEIGHT-1`, move to DRAIN.
- Filter feed: `flt_valid` is `src_req` delayed 1 cycle; `flt_pix` = `src_rdata` on that cycle.
- Result capture:
  - On `flt_out_valid`, push {`flt_row*IMAGE_WIDTH+flt_col` truncated to ADDR_W, `flt_out`}.
  - Push while full: the entry is dropped and `ovf` is set.
- Write side:
  - `dst_we` = FIFO non-empty; `dst_addr`/`dst_data` = head entry.
  - Pop when `dst_we & dst_ready`.
  - Push and pop in the same cycle leaves the count unchanged, and that push is legal when full.
- DRAIN: wait at least 4 cycles after entry and until the FIFO is empty, then DONE.
- DONE (1 cycle): `done`=1, then IDLE.
- `flt_rst` = `rst` OR CLEAR.

## Timing
- Reset values:
  - `busy`, `done`, `ovf`, `src_req`, `flt_valid`, `dst_we` = 0.
  - `src_addr`, `dst_addr`, `flt_pix`, `dst_data`, `sat_count` = 0.
  - State IDLE, FIFO empty.
- `start` at cycle t: CLEAR at t+1, first `src_req` at t+2, first `flt_valid` at t+3.
- Unstalled frame: `src_req` is continuous for W*H cycles.
- `busy` rises the cycle after `start` and falls the cycle after the `done` pulse.
- `rst` mid-frame: the next cycle shows reset values. In-flight reads and FIFO contents are discarded, and `ovf` is cleared.
- `src_req` deasserts on the cycle free slots drop below 4, and resumes the cycle after they return to ≥4.

## Configuration
- `LAP_FRAME_STATS_EN` defined:
  - `sat_count` increments on each pushed result equal to 0 or 255.
  - It is cleared in CLEAR and on rst.
- `LAP_FRAME_STATS_EN` not defined: `sat_count` is constant 0 and no counter logic is built.

## Structure
- Shared package `lap_pkg` holds:
  - the state enum;
  - the FIFO entry typedef {addr, data};
  - `LAP_INFLIGHT_MAX`=3;
  - `LAP_DRAIN_CYCLES`=4.
- One sub-module: `lap_result_fifo`, a synchronous FIFO exposing count/full/empty.

## Test plan
All cases use W=4, H=3.
- Flat frame, all pixels 100 → every `dst_data`=128; `src_addr` 0..11 each issued once; one `done`; `ovf`=0.
- `dst_ready`=0 for 20 cycles during STREAM → `src_req` drops within 1 cycle of free<4; no results lost; `ovf`=0; write order preserved.
- `start` pulsed during STREAM and during DONE → ignored. A subsequent `start` in IDLE → a second complete frame.
- `rst` at the 6th request → the next cycle shows all outputs at reset values and `flt_rst`=1; a later `start` produces a correct frame.
- Centre pixel 255 with all neighbours 0 → result 255. Centre 0 with neighbours 255 → result 0. With `LAP_FRAME_STATS_EN`, `sat_count` counts both.
- Force `flt_out_valid` pushes with the FIFO full and `dst_ready`=0 → `ovf`=1, sticky until rst.
